// File: rtl/fc_layer_par_stream.sv
// Fully-connected layer y = act(W*x + b) with run-time loaded weights, P parallel MAC
// lanes, a double-buffered input vector and a P-entry output buffer.
module fc_layer_par_stream #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [T-1:0] cfg_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [T-1:0] data_in,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [T-1:0] data_out
);

  localparam int G  = M / P;
  localparam int AW = 2 * T + $clog2(N + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  localparam logic [1:0] CFG_W = 2'd0;
  localparam logic [1:0] CFG_B = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_col;
  logic [LW-1:0]       r_lane;
  logic [GW-1:0]       r_cgrp;

  logic signed [T-1:0] r_w [P][G][N];
  logic signed [T-1:0] r_b [P][G];
  logic signed [T-1:0] r_x [2][N];

  logic [1:0]          r_full;
  logic                r_fill_sel;
  logic [CW-1:0]       r_fill_cnt;

  logic                r_cmp_sel;
  logic                r_busy;
  logic                r_wb;
  logic [GW-1:0]       r_grp;
  logic [CW-1:0]       r_j;
  logic signed [AW-1:0] r_acc [P];

  logic signed [T-1:0] r_obuf [P];
  logic                r_ovalid;
  logic [LW-1:0]       r_oidx;

  logic                w_cfg_hs, w_s_hs, w_m_hs, w_reload, w_clear;
  logic                w_start, w_mac, w_wb_load, w_last_grp;
  logic                w_col_last, w_lane_last, w_cgrp_last;
  logic [GW-1:0]       w_grp_nxt, w_bgrp;
  logic signed [T-1:0] w_xsel;
  logic signed [AW-1:0] w_xext;
  logic signed [AW-1:0] w_wext [P];
  logic signed [AW-1:0] w_bext [P];
  logic signed [T-1:0] w_res  [P];

  assign cfg_ready = (r_state != RUN) || (r_full == 2'b00 && !r_busy && !r_ovalid);
  assign s_ready   = (r_state == RUN) && !r_full[r_fill_sel];
  assign m_valid   = r_ovalid;
  assign data_out  = r_obuf[r_oidx];

  assign w_cfg_hs  = cfg_valid && cfg_ready;
  assign w_s_hs    = s_valid && s_ready;
  assign w_m_hs    = r_ovalid && m_ready;
  assign w_reload  = w_cfg_hs && (r_state == RUN);
  assign w_clear   = reset || w_reload;

  assign w_col_last  = (r_col == CW'(N - 1));
  assign w_lane_last = (r_lane == LW'(P - 1));
  assign w_cgrp_last = (r_cgrp == GW'(G - 1));

  assign w_start    = !r_busy && r_full[r_cmp_sel];
  assign w_mac      = r_busy && !r_wb;
  assign w_wb_load  = r_busy && r_wb && !r_ovalid;
  assign w_last_grp = (r_grp == GW'(G - 1));
  assign w_grp_nxt  = r_grp + 1'b1;
  assign w_bgrp     = w_start ? '0 : w_grp_nxt;
  assign w_xsel     = r_x[r_cmp_sel][r_j];

  // A config word seen in RUN is W[0][0] of a reload: counters are all zero there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CFG_W;
      r_col   <= '0;
      r_lane  <= '0;
      r_cgrp  <= '0;
    end else if (w_cfg_hs) begin
      if (r_state == CFG_B) begin
        r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
        if (w_lane_last) begin
          r_cgrp <= w_cgrp_last ? '0 : r_cgrp + 1'b1;
          if (w_cgrp_last) r_state <= RUN;
        end
      end else begin
        r_state <= CFG_W;
        r_col   <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) begin
          r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
          if (w_lane_last) begin
            r_cgrp <= w_cgrp_last ? '0 : r_cgrp + 1'b1;
            if (w_cgrp_last) r_state <= CFG_B;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cfg_hs && r_state == CFG_B) r_b[r_lane][r_cgrp] <= cfg_data;
    if (w_cfg_hs && r_state != CFG_B) r_w[r_lane][r_cgrp][r_col] <= cfg_data;
    if (w_s_hs) r_x[r_fill_sel][r_fill_cnt] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_full     <= '0;
      r_fill_sel <= 1'b0;
      r_fill_cnt <= '0;
    end else begin
      if (w_s_hs) begin
        if (r_fill_cnt == CW'(N - 1)) begin
          r_full[r_fill_sel] <= 1'b1;
          r_fill_sel         <= ~r_fill_sel;
          r_fill_cnt         <= '0;
        end else begin
          r_fill_cnt <= r_fill_cnt + 1'b1;
        end
      end
      if (w_wb_load && w_last_grp) r_full[r_cmp_sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_busy    <= 1'b0;
      r_wb      <= 1'b0;
      r_grp     <= '0;
      r_j       <= '0;
      r_cmp_sel <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_wb   <= 1'b0;
      r_grp  <= '0;
      r_j    <= '0;
    end else if (w_mac) begin
      if (r_j == CW'(N - 1)) begin
        r_wb <= 1'b1;
        r_j  <= '0;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end else if (w_wb_load) begin
      r_wb <= 1'b0;
      if (w_last_grp) begin
        r_busy    <= 1'b0;
        r_grp     <= '0;
        r_cmp_sel <= ~r_cmp_sel;
      end else begin
        r_grp <= w_grp_nxt;
      end
    end
  end

  always_comb begin
    w_xext = {{(AW-T){w_xsel[T-1]}}, w_xsel};
    for (int unsigned k = 0; k < P; k++) begin
      w_wext[k] = {{(AW-T){r_w[k][r_grp][r_j][T-1]}}, r_w[k][r_grp][r_j]};
      w_bext[k] = {{(AW-T){r_b[k][w_bgrp][T-1]}}, r_b[k][w_bgrp]};
      w_res[k]  = r_acc[k][T-1:0];
      if (r_acc[k] > SAT_MAX)      w_res[k] = SAT_MAX[T-1:0];
      else if (r_acc[k] < SAT_MIN) w_res[k] = SAT_MIN[T-1:0];
      if (RELU != 0 && w_res[k][T-1]) w_res[k] = '0;
    end
  end

  // Accumulators hold during a writeback stall; the next group's bias is loaded on release.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < P; k++) begin
      if (w_clear)                                 r_acc[k] <= '0;
      else if (w_start || (w_wb_load && !w_last_grp)) r_acc[k] <= w_bext[k];
      else if (w_mac)                              r_acc[k] <= r_acc[k] + w_wext[k] * w_xext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovalid <= 1'b0;
      r_oidx   <= '0;
      for (int unsigned k = 0; k < P; k++) r_obuf[k] <= '0;
    end else if (w_wb_load) begin
      r_ovalid <= 1'b1;
      r_oidx   <= '0;
      for (int unsigned k = 0; k < P; k++) r_obuf[k] <= w_res[k];
    end else if (w_m_hs) begin
      if (r_oidx == LW'(P - 1)) begin
        r_ovalid <= 1'b0;
        r_oidx   <= '0;
      end else begin
        r_oidx <= r_oidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_par_stream.sv
// Directed bench for fc_layer_par_stream (T=8, M=4, N=3, P=2) with a RELU=0 and a
// RELU=1 instance sharing all inputs.
module tb_fc_layer_par_stream;

  localparam int M = 4;
  localparam int N = 3;
  localparam int T = 8;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [T-1:0] cfg_data;
  logic         s_valid;
  logic [T-1:0] data_in;
  logic         m_ready;
  logic         cfg_ready, s_ready, m_valid;
  logic [T-1:0] data_out;
  logic         cfg_ready_r, s_ready_r, m_valid_r;
  logic [T-1:0] data_out_r;

  fc_layer_par_stream #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) u_dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out)
  );

  fc_layer_par_stream #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) u_dut_relu (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_r), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
    .m_valid(m_valid_r), .m_ready(m_ready), .data_out(data_out_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [N-1:0][7:0] x;
    logic [M-1:0][7:0] y;
    logic [M-1:0][7:0] yr;
  } vec_t;

  vec_t        tbl [6];
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          last_acc_cyc = 0;
  int          words_acc = 0;
  int          first_stall = -1;

  function automatic vec_t mk(input int x0, x1, x2, y0, y1, y2, y3, r0, r1, r2, r3);
    vec_t v;
    v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2);
    v.y[0] = 8'(y0); v.y[1] = 8'(y1); v.y[2] = 8'(y2); v.y[3] = 8'(y3);
    v.yr[0] = 8'(r0); v.yr[1] = 8'(r1); v.yr[2] = 8'(r2); v.yr[3] = 8'(r3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg_word(input int d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = 8'(d);
    while (!cfg_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("cfg_timeout", 0, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_cfg();
    int cw [16] = '{1, 2, 3, -1, -2, -3, 4, 0, -4, 100, 100, 100, 0, 5, -1, 0};
    for (int i = 0; i < 16; i++) send_cfg_word(cw[i]);
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < M; i++) exp_q.push_back({v.y[i], v.yr[i]});
  endtask

  task automatic send_x(input vec_t v);
    for (int j = 0; j < N; j++) begin
      int n = 0;
      s_valid = 1'b1;
      data_in = v.x[j];
      while (!s_ready && n < 300) begin
        if (first_stall < 0) first_stall = words_acc;
        tick(); n++;
      end
      if (n >= 300) chk("s_timeout", 0, 1);
      if (j == N - 1) last_acc_cyc = cyc;
      words_acc++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string nm);
    int n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    if (n >= 100) chk(nm, 0, 1);
  endtask

  // bp=1 drives m_ready with the repeating pattern 1,0,0,1 and checks output holding.
  task automatic consume(input int cnt, input bit bp);
    int          got = 0;
    int          ph = 0;
    int          guard = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_d = '0;
    logic [15:0] e;
    while (got < cnt && guard < 3000) begin
      m_ready = bp ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
      ph++;
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", $signed(data_out), $signed(prev_d));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", $signed(data_out), 0);
          chk("unexpected_output_count", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y", $signed(data_out), $signed(e[15:8]));
          chk("y_relu", $signed(data_out_r), $signed(e[7:0]));
        end
        got++;
      end
      prev_hold = m_valid && !m_ready;
      prev_d    = data_out;
      tick();
      guard++;
    end
    if (got < cnt) chk("consume_timeout", got, cnt);
    m_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(   1,    1,    1,    6,  -1, -1,  127,  6,   0, 0, 127);
    tbl[1] = mk(  -2,   -2,   -2,  -12,  17, -1, -128,  0,  17, 0,   0);
    tbl[2] = mk(   3,   -1,    2,    7,  -2,  3,  127,  7,   0, 3, 127);
    tbl[3] = mk(   0,    0,    0,    0,   5, -1,    0,  0,   5, 0,   0);
    tbl[4] = mk(  -1,    2,   -3,   -6,  11,  7, -128,  0,  11, 7,   0);
    tbl[5] = mk(-128, -128, -128, -128, 127, -1, -128,  0, 127, 0,   0);

    reset = 1'b1; cfg_valid = 1'b0; cfg_data = '0; s_valid = 1'b0; data_in = '0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_relu_handshakes", 32'({cfg_ready_r, s_ready_r, m_valid_r}), 32'b100);

    load_cfg();
    chk("run_s_ready", 32'(s_ready), 1);

    // Table: each vector on an idle engine; vector 0 also checks latency and backpressure.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i]);
      send_x(tbl[i]);
      if (i == 0) begin
        wait_mvalid("latency_timeout");
        chk("latency", cyc - last_acc_cyc, N + 3);
      end
      consume(M, i == 0);
      chk("queue_empty", exp_q.size(), 0);
    end

    // Output stalled: one vector parked in the engine plus one more fills both banks.
    m_ready = 1'b0;
    push_exp(tbl[1]);
    push_exp(tbl[2]);
    send_x(tbl[1]);
    wait_mvalid("stall_mvalid_timeout");
    chk("busy_cfg_ready", 32'(cfg_ready), 0);
    send_x(tbl[2]);
    repeat (20) tick();
    chk("full_s_ready", 32'(s_ready), 0);
    chk("stall_data", $signed(data_out), $signed(tbl[1].y[0]));
    consume(2 * M, 1'b1);

    // Back-to-back vectors with s_valid held.
    words_acc   = 0;
    first_stall = -1;
    push_exp(tbl[3]);
    push_exp(tbl[4]);
    push_exp(tbl[5]);
    fork
      begin
        send_x(tbl[3]);
        send_x(tbl[4]);
        send_x(tbl[5]);
      end
      consume(3 * M, 1'b0);
    join
    chk("first_stall_words", first_stall, 2 * N);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Reload while idle in RUN.
    tick();
    chk("idle_cfg_ready", 32'(cfg_ready), 1);
    load_cfg();
    push_exp(tbl[0]);
    send_x(tbl[0]);
    consume(M, 1'b0);

    // Reset after group 0 writeback.
    m_ready = 1'b0;
    send_x(tbl[0]);
    wait_mvalid("pre_reset_timeout");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 1);
    repeat (3) tick();
    chk("unconfigured_s_ready", 32'(s_ready), 0);
    load_cfg();
    push_exp(tbl[0]);
    m_ready = 1'b1;
    send_x(tbl[0]);
    consume(M, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
